fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS core, sitting directly upstream of the decode stage. Owns the program counter, drives a variable-latency instruction-memory request/acknowledge handshake, and contains the IF/ID pipeline register that supplies the decode stage with the instruction word and PC+4. It accepts redirects (taken branch, jump, jump-register) computed in decode, and it inserts bubbles whenever no valid instruction is available.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_stage_if_id_reg.sv | 47 ++++
 rtl/fetch_stage.sv | 188 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: fetch FSM state encoding,
// the NOP instruction word and the program-counter increment.
package mips_pkg;

  // Fetch FSM states. The encoding is also visible on the fetch stage's
  // state debug output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  // All-zero word; decodes as sll $0,$0,0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Byte distance between consecutive instructions.
  localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. It loads when enabled. A synchronous clear
// inserts a bubble: the instruction becomes NOP, valid drops, and PC+4
// keeps its previous value. Asynchronous active-low reset to all zero.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int IW = 32,
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [IW-1:0] instr_i,
  input  logic [AW-1:0] pc_plus4_i,
  output logic [IW-1:0] instr_o,
  output logic [AW-1:0] pc_plus4_o,
  output logic          valid_o
);

  logic [IW-1:0] instr_q;
  logic [AW-1:0] pc_plus4_q;
  logic          valid_q;

  // Load a real instruction or a bubble when enabled; otherwise hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (en_i) begin
      if (clr_i) begin
        instr_q <= IW'(NOP_INSTR);
        valid_q <= 1'b0;
      end else begin
        instr_q    <= instr_i;
        pc_plus4_q <= pc_plus4_i;
        valid_q    <= 1'b1;
      end
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. It owns PCF,
// runs the instruction-memory handshake, and feeds decode through the
// IF/ID register.
//
// Optional build macro FETCH_STAGE_PERF_EN adds two 32-bit counters:
// o_FetchCnt counts valid IF/ID loads and o_BubbleCnt counts bubble loads.
//
// Memory handshake: o_IMemReq and o_IMemAddr come straight from registers.
// They stay stable until the memory returns i_IMemAck for exactly one
// cycle, and i_IMemRdata is valid only in that cycle. Ack may arrive in the
// same cycle as the request, which gives one instruction per cycle.
// Decode-side control: i_StallD freezes the PC and IF/ID. i_PCSrcD is
// honoured only when i_StallD is low.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       INSTR_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h0000_0000
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic                     i_StallD,
  input  logic                     i_PCSrcD,
  input  logic [ADDRESS_WIDTH-1:0] i_PCNextD,
  output logic                     o_IMemReq,
  output logic [ADDRESS_WIDTH-1:0] o_IMemAddr,
  input  logic                     i_IMemAck,
  input  logic [INSTR_WIDTH-1:0]   i_IMemRdata,
  output logic [INSTR_WIDTH-1:0]   o_InstrD,
  output logic [ADDRESS_WIDTH-1:0] o_PCPlus4D,
  output logic                     o_ValidD,
`ifdef FETCH_STAGE_PERF_EN
  output logic [31:0]              o_FetchCnt,
  output logic [31:0]              o_BubbleCnt,
`endif
  output logic [1:0]               o_StateDbg
);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pcf_q, pcf_d;
  logic [INSTR_WIDTH-1:0]   skid_q, skid_d;
  logic [ADDRESS_WIDTH-1:0] redir_q, redir_d;
  logic                     req_q, req_d;

  logic [ADDRESS_WIDTH-1:0] pc_plus4_f;
  logic                     taken;
  logic                     ifid_en;
  logic                     ifid_clr;
  logic [INSTR_WIDTH-1:0]   ifid_instr;

  assign pc_plus4_f = pcf_q + ADDRESS_WIDTH'(PC_INCR);
  // A redirect is ignored while decode is stalled; the hazard unit repeats it.
  assign taken      = i_PCSrcD & ~i_StallD;

  // Next-state, PC and IF/ID control for the fetch FSM.
  always_comb begin
    state_d    = state_q;
    pcf_d      = pcf_q;
    skid_d     = skid_q;
    redir_d    = redir_q;
    ifid_en    = 1'b0;
    ifid_clr   = 1'b0;
    ifid_instr = i_IMemRdata;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (i_StallD) begin
          // Decode is frozen. Park a returning word until the stall clears.
          if (i_IMemAck) begin
            skid_d  = i_IMemRdata;
            state_d = ST_HOLD;
          end
        end else begin
          ifid_en = 1'b1;
          if (i_IMemAck) begin
            if (i_PCSrcD) begin
              ifid_clr = 1'b1;
              pcf_d    = i_PCNextD;
            end else begin
              pcf_d = pc_plus4_f;
            end
          end else begin
            ifid_clr = 1'b1;
            if (i_PCSrcD) begin
              // The in-flight request must finish before the target is fetched.
              redir_d = i_PCNextD;
              state_d = ST_DISCARD;
            end
          end
        end
      end
      ST_HOLD: begin
        if (!i_StallD) begin
          ifid_en    = 1'b1;
          ifid_instr = skid_q;
          state_d    = ST_REQ;
          if (i_PCSrcD) begin
            ifid_clr = 1'b1;
            pcf_d    = i_PCNextD;
          end else begin
            pcf_d = pc_plus4_f;
          end
        end
      end
      ST_DISCARD: begin
        if (!i_StallD) begin
          ifid_en  = 1'b1;
          ifid_clr = 1'b1;
          if (i_PCSrcD) begin
            redir_d = i_PCNextD;
          end
        end
        if (i_IMemAck) begin
          // The returning word is stale. If a redirect arrives in this
          // same cycle, its target wins over the saved one.
          pcf_d   = taken ? i_PCNextD : redir_q;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d = (state_d == ST_REQ) || (state_d == ST_DISCARD);
  end

  // FSM state, PC, skid buffer, redirect target and registered request.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q <= ST_IDLE;
      pcf_q   <= RESET_PC;
      skid_q  <= '0;
      redir_q <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      skid_q  <= skid_d;
      redir_q <= redir_d;
      req_q   <= req_d;
    end
  end

  assign o_IMemReq  = req_q;
  assign o_IMemAddr = pcf_q;
  assign o_StateDbg = state_q;

  if_id_reg #(
    .IW(INSTR_WIDTH),
    .AW(ADDRESS_WIDTH)
  ) u_if_id (
    .clk_i      (i_CLK),
    .rst_ni     (i_RST),
    .en_i       (ifid_en),
    .clr_i      (ifid_clr),
    .instr_i    (ifid_instr),
    .pc_plus4_i (pc_plus4_f),
    .instr_o    (o_InstrD),
    .pc_plus4_o (o_PCPlus4D),
    .valid_o    (o_ValidD)
  );

`ifdef FETCH_STAGE_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Count every IF/ID load, split by real instruction versus bubble.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (ifid_en) begin
      if (ifid_clr) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end else begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

  assign o_FetchCnt  = fetch_cnt_q;
  assign o_BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. A memory driver with random latency, random
// stalls and redirects feeds the DUT. A program-order reference model
// (expected next PC plus a queue of fetched words) predicts what decode
// must see, and a negedge monitor compares it against IF/ID.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam int          AW     = 32;
  localparam int          IW     = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic          clk;
  logic          rst_n;
  logic          i_StallD;
  logic          i_PCSrcD;
  logic [AW-1:0] i_PCNextD;
  logic          o_IMemReq;
  logic [AW-1:0] o_IMemAddr;
  logic          i_IMemAck;
  logic [IW-1:0] i_IMemRdata;
  logic [IW-1:0] o_InstrD;
  logic [AW-1:0] o_PCPlus4D;
  logic          o_ValidD;
  logic [1:0]    o_StateDbg;
`ifdef FETCH_STAGE_PERF_EN
  logic [31:0]   fetch_cnt;
  logic [31:0]   bubble_cnt;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage #(
    .ADDRESS_WIDTH(AW),
    .INSTR_WIDTH  (IW),
    .RESET_PC     (RST_PC)
  ) dut (
    .i_CLK      (clk),
    .i_RST      (rst_n),
    .i_StallD   (i_StallD),
    .i_PCSrcD   (i_PCSrcD),
    .i_PCNextD  (i_PCNextD),
    .o_IMemReq  (o_IMemReq),
    .o_IMemAddr (o_IMemAddr),
    .i_IMemAck  (i_IMemAck),
    .i_IMemRdata(i_IMemRdata),
    .o_InstrD   (o_InstrD),
    .o_PCPlus4D (o_PCPlus4D),
    .o_ValidD   (o_ValidD),
`ifdef FETCH_STAGE_PERF_EN
    .o_FetchCnt (fetch_cnt),
    .o_BubbleCnt(bubble_cnt),
`endif
    .o_StateDbg (o_StateDbg)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory contents: a fixed, address-derived word that is never zero.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // ---------------- reference model state ----------------
  logic [63:0] exp_q[$];     // {instr, pc_plus4} in delivery order
  logic [31:0] exp_pc;       // address of the next useful fetch
  int          n_deliv = 0;

  // Stimulus knobs and driver state.
  int          lat_min, lat_max, stall_pct, redir_pct;
  int          lat_left;
  int          cyc;
  int          force_stall_n;
  bit          force_redir;
  logic [31:0] force_tgt;
  bit          chk_tgt_pend;
  logic [31:0] chk_tgt;
  bit          prev_wait;
  logic [31:0] prev_addr;

  task automatic clear_model();
    exp_q.delete();
    exp_pc        = RST_PC;
    cyc           = 0;
    lat_left      = -1;
    chk_tgt_pend  = 0;
    prev_wait     = 0;
    force_redir   = 0;
    force_stall_n = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic zero_inputs();
    i_StallD    = 1'b0;
    i_PCSrcD    = 1'b0;
    i_PCNextD   = '0;
    i_IMemAck   = 1'b0;
    i_IMemRdata = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_req",   {31'd0, o_IMemReq}, 32'd0);
    check("rst_addr",  o_IMemAddr, RST_PC);
    check("rst_instr", o_InstrD, 32'd0);
    check("rst_pc4",   o_PCPlus4D, 32'd0);
    check("rst_valid", {31'd0, o_ValidD}, 32'd0);
    check("rst_state", {30'd0, o_StateDbg}, {30'd0, ST_IDLE});
  endtask

  // Hold reset for two edges, release it just after an edge, and check
  // that the release cycle is still idle.
  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_model();
    check("idle_req", {31'd0, o_IMemReq}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  // Drive one cycle of memory, stall and redirect stimulus.
  task automatic drive_cycle();
    logic        ack;
    logic [31:0] tgt;
    cyc++;
    if (cyc == 1) begin
      check("first_req",  {31'd0, o_IMemReq}, 32'd1);
      check("first_addr", o_IMemAddr, RST_PC);
    end
    if (o_IMemReq) begin
      if (lat_left < 0) lat_left = $urandom_range(lat_max, lat_min);
      ack = (lat_left == 0);
      if (ack) lat_left = -1;
      else     lat_left--;
    end else begin
      ack      = 1'b0;
      lat_left = -1;
    end
    i_IMemAck   = ack;
    i_IMemRdata = ack ? mem_word(o_IMemAddr) : $urandom();
    if (force_stall_n > 0) begin
      i_StallD = 1'b1;
      force_stall_n--;
    end else if (force_redir) begin
      i_StallD = 1'b0;
    end else begin
      i_StallD = ($urandom_range(0, 99) < stall_pct);
    end
    if (force_redir) begin
      i_PCSrcD    = 1'b1;
      i_PCNextD   = force_tgt;
      force_redir = 0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      do tgt = $urandom() & 32'hFFFF_FFFC; while (tgt == o_IMemAddr);
      i_PCSrcD  = 1'b1;
      i_PCNextD = tgt;
    end else begin
      i_PCSrcD  = 1'b0;
      i_PCNextD = $urandom();
    end
  endtask

  // Reference model update for the cycle just driven, in program order.
  task automatic model_update();
    bit taken;
    taken = i_PCSrcD && !i_StallD;
    if (i_IMemAck && !taken && (o_IMemAddr == exp_pc)) begin
      exp_q.push_back({mem_word(exp_pc), exp_pc + 32'd4});
      exp_pc = exp_pc + 32'd4;
    end
    if (taken) begin
      exp_q.delete();
      exp_pc = i_PCNextD;
      if (i_IMemAck || !o_IMemReq) begin
        chk_tgt_pend = 1;
        chk_tgt      = i_PCNextD;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_cycle();
      @(negedge clk);
      #1;
      model_update();
    end
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int sp, input int rp);
    lat_min   = lmin;
    lat_max   = lmax;
    stall_pct = sp;
    redir_pct = rp;
  endtask

  // Advance until the pending request will not be acked next cycle.
  task automatic wait_pending(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      run_cycles(1);
      if (o_IMemReq && lat_left >= 1) found = 1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      logic [63:0] e;
      if (chk_tgt_pend) begin
        check("redir_addr",   o_IMemAddr, chk_tgt);
        check("redir_req",    {31'd0, o_IMemReq}, 32'd1);
        check("redir_bubble", {31'd0, o_ValidD}, 32'd0);
        chk_tgt_pend = 0;
      end
      if (prev_wait) begin
        check("req_hold",  {31'd0, o_IMemReq}, 32'd1);
        check("addr_hold", o_IMemAddr, prev_addr);
      end
      prev_wait = o_IMemReq && !i_IMemAck;
      prev_addr = o_IMemAddr;
      if (!o_ValidD) begin
        check("bubble_nop", o_InstrD, 32'd0);
      end else if (!i_StallD) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_instr: got %h pc4 %h, expected none", o_InstrD, o_PCPlus4D);
        end else begin
          e = exp_q.pop_front();
          check("instr",    o_InstrD, e[63:32]);
          check("pc_plus4", o_PCPlus4D, e[31:0]);
          n_deliv++;
        end
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    int          d0;
    logic [31:0] old_addr;
    rst_n = 1'b0;
    zero_inputs();
    clear_model();
    set_knobs(0, 0, 0, 0);
    #1;
    check_reset_outputs();
    release_reset();

    // Zero-wait memory: one instruction per cycle.
    d0 = n_deliv;
    run_cycles(20);
    check("zero_wait_tput", n_deliv - d0, 32'd19);

    // Three-cycle ack latency: request held, one instruction every 4 cycles.
    set_knobs(3, 3, 0, 0);
    d0 = n_deliv;
    run_cycles(20);
    check("lat3_deliveries", n_deliv - d0, 32'd5);

    // Redirect coinciding with an ack.
    set_knobs(0, 0, 0, 0);
    force_redir = 1;
    force_tgt   = 32'h0000_0100;
    run_cycles(6);

    // Redirect while a request is still pending: stale fetch completes first.
    set_knobs(3, 3, 0, 0);
    wait_pending("find_pending1");
    old_addr    = o_IMemAddr;
    force_redir = 1;
    force_tgt   = old_addr + 32'h0000_1000;
    run_cycles(2);
    check("discard_state", {30'd0, o_StateDbg}, {30'd0, ST_DISCARD});
    check("discard_addr",  o_IMemAddr, old_addr);
    run_cycles(10);

    // Asynchronous reset in the middle of DISCARD.
    wait_pending("find_pending2");
    force_redir = 1;
    force_tgt   = o_IMemAddr + 32'h0000_2000;
    run_cycles(1);
    @(posedge clk);
    #1;
    check("pre_reset_state", {30'd0, o_StateDbg}, {30'd0, ST_DISCARD});
    #2;
    rst_n = 1'b0;
    zero_inputs();
    #1;
    check_reset_outputs();
    release_reset();
    set_knobs(0, 0, 0, 0);
    run_cycles(3);

    // Two-cycle stall coinciding with an ack: word parked, request dropped.
    force_stall_n = 2;
    run_cycles(2);
    check("hold_req",   {31'd0, o_IMemReq}, 32'd0);
    check("hold_state", {30'd0, o_StateDbg}, {30'd0, ST_HOLD});
    run_cycles(5);

    // PC wrap at the top of the address space.
    force_redir = 1;
    force_tgt   = 32'hFFFF_FFF8;
    run_cycles(6);

    // Randomized mix of latency, stalls and redirects.
    set_knobs(0, 3, 25, 8);
    run_cycles(3000);

    // Drain and end-of-run sanity.
    set_knobs(0, 0, 0, 0);
    run_cycles(10);
    check("drain_queue", {31'd0, exp_q.size() <= 1}, 32'd1);
    check("liveness",    {31'd0, n_deliv > 300}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
